// File: rtl/world.sv
// Player-physics core: walking, jumping and gravity advanced once per game tick,
// producing Mario's screen-space sprite position and sprite frame ID.
module world #(
    parameter int GROUND_Y  = 400,
    parameter int WALK_STEP = 4,
    parameter int JUMP_V    = 12,
    parameter int GRAVITY   = 1,
    parameter int X_SPAN    = 624
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_10,
    input  logic        jump,
    input  logic        left,
    input  logic        right,
    input  logic [32:0] view,
    output logic [10:0] mario_x,
    output logic [9:0]  mario_y,
    output logic [5:0]  mario_id
);

    localparam logic [32:0]        START_X  = 33'd64;
    localparam logic [9:0]         START_Y  = 10'(GROUND_Y);
    localparam logic [10:0]        START_SX = 11'd64;
    localparam logic signed [7:0]  VY_LAUNCH = 8'(GRAVITY - JUMP_V);
    localparam logic signed [7:0]  VY_GRAV   = 8'(GRAVITY);
    localparam logic signed [34:0] STEP      = 35'(WALK_STEP);
    localparam logic signed [34:0] SPAN      = 35'(X_SPAN);
    localparam logic signed [11:0] GROUND_S  = 12'(GROUND_Y);
    localparam logic [9:0]         JUMP_DY   = 10'(JUMP_V);
    localparam logic [4:0]         FRAME_AIR = 5'd4;

    function automatic logic signed [34:0] clamp_x(input logic signed [34:0] pos,
                                                   input logic signed [34:0] lo,
                                                   input logic signed [34:0] hi);
        if (pos < lo)
            return lo;
        else if (pos > hi)
            return hi;
        else
            return pos;
    endfunction

    function automatic logic [1:0] next_frame(input logic [1:0] f);
        return (f == 2'd3) ? 2'd1 : f + 2'd1;
    endfunction

    function automatic logic [5:0] sprite_id(input logic       airborne,
                                             input logic       walking,
                                             input logic [1:0] frame_cur,
                                             input logic       face_left);
        logic [4:0] sel;
        if (airborne)
            sel = FRAME_AIR;
        else if (walking)
            sel = {3'b000, frame_cur};
        else
            sel = 5'd0;
        return {face_left, sel};
    endfunction

    // Stage p0..p2: two-flop synchronizer plus edge register on the game strobe.
    // vld_pN marks when sync_p1 holds a genuinely sampled level after reset; the
    // strobe must be seen low once before a rising edge may produce a tick.
    logic sync_p0, sync_p1, sync_p2;
    logic vld_p0, vld_p1;
    logic armed;
    logic tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            armed   <= 1'b0;
        end else begin
            sync_p0 <= clk_10;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
            vld_p0  <= 1'b1;
            vld_p1  <= vld_p0;
            armed   <= armed | (vld_p1 & ~sync_p1);
        end
    end

    assign tick = armed & sync_p1 & ~sync_p2;

    logic [32:0]        world_x;
    logic [9:0]         y;
    logic signed [7:0]  vy;
    logic               air;
    logic               facing;
    logic [1:0]         frame;

    logic               go_right, go_left, moving, launch, airborne, walking;
    logic signed [34:0] lo, hi, wx_step, wx_clamped, x_off;
    logic signed [11:0] y_sum;
    logic [32:0]        world_x_nxt;
    logic [10:0]        mario_x_nxt;
    logic [9:0]         y_nxt;
    logic signed [7:0]  vy_nxt;
    logic               air_nxt, facing_nxt;
    logic [1:0]         frame_nxt;
    logic [5:0]         id_nxt;

    always_comb begin
        go_right = right & ~left;
        go_left  = left & ~right;
        moving   = go_right | go_left;
        launch   = ~air & jump;

        lo      = signed'({2'b00, view});
        hi      = lo + SPAN;
        wx_step = signed'({2'b00, world_x});
        if (go_right)
            wx_step = wx_step + STEP;
        else if (go_left)
            wx_step = wx_step - STEP;
        wx_clamped  = clamp_x(wx_step, lo, hi);
        x_off       = wx_clamped - lo;
        world_x_nxt = wx_clamped[32:0];
        mario_x_nxt = x_off[10:0];

        facing_nxt = facing;
        if (go_left)
            facing_nxt = 1'b1;
        else if (go_right)
            facing_nxt = 1'b0;

        y_sum   = signed'({2'b00, y}) + 12'(vy);
        y_nxt   = y;
        vy_nxt  = vy;
        air_nxt = air;
        if (launch) begin
            y_nxt   = y - JUMP_DY;
            vy_nxt  = VY_LAUNCH;
            air_nxt = 1'b1;
        end else if (air) begin
            if (y_sum >= GROUND_S) begin
                y_nxt   = START_Y;
                vy_nxt  = 8'sd0;
                air_nxt = 1'b0;
            end else begin
                y_nxt  = y_sum[9:0];
                vy_nxt = vy + VY_GRAV;
            end
        end

        // The landing tick still shows the airborne frame.
        airborne  = air | launch;
        walking   = ~airborne & moving;
        frame_nxt = frame;
        if (walking)
            frame_nxt = next_frame(frame);
        else if (!airborne)
            frame_nxt = 2'd1;
        id_nxt = sprite_id(airborne, walking, frame, facing_nxt);
    end

    // Stage p3: tick-qualified physics state and registered sprite outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            world_x  <= START_X;
            y        <= START_Y;
            vy       <= 8'sd0;
            air      <= 1'b0;
            facing   <= 1'b0;
            frame    <= 2'd1;
            mario_x  <= START_SX;
            mario_y  <= START_Y;
            mario_id <= 6'd0;
        end else if (tick) begin
            world_x  <= world_x_nxt;
            y        <= y_nxt;
            vy       <= vy_nxt;
            air      <= air_nxt;
            facing   <= facing_nxt;
            frame    <= frame_nxt;
            mario_x  <= mario_x_nxt;
            mario_y  <= y_nxt;
            mario_id <= id_nxt;
        end
    end

endmodule

// File: tb/tb_world.sv
// Bench for world: vector table of per-tick stimulus and expected sprite outputs,
// plus a hand-written mid-jump asynchronous reset sequence.
module tb_world;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        clk_10 = 1'b0;
    logic        jump   = 1'b0;
    logic        left   = 1'b0;
    logic        right  = 1'b0;
    logic [32:0] view   = 33'd0;
    logic [10:0] mario_x;
    logic [9:0]  mario_y;
    logic [5:0]  mario_id;

    world dut (
        .clk      (clk),
        .rst      (rst),
        .clk_10   (clk_10),
        .jump     (jump),
        .left     (left),
        .right    (right),
        .view     (view),
        .mario_x  (mario_x),
        .mario_y  (mario_y),
        .mario_id (mario_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          do_rst;
        bit          r;
        bit          l;
        bit          j;
        logic [32:0] v;
        int          ex;
        int          ey;
        int          eid;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   passed = 0;
    int   total  = 0;
    int   prev_x = 64;
    int   prev_y = 400;
    int   prev_id = 0;

    localparam int ARC_LEN = 26;
    int arc [ARC_LEN] = '{388, 377, 367, 358, 350, 343, 337, 332, 328, 325, 323, 322, 322,
                          323, 325, 328, 332, 337, 343, 350, 358, 367, 377, 388, 400, 388};

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp)
            passed++;
        else
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check3(input string name, input int ex, input int ey, input int eid);
        check({name, ".mario_x"}, int'(mario_x), ex);
        check({name, ".mario_y"}, int'(mario_y), ey);
        check({name, ".mario_id"}, int'(mario_id), eid);
    endtask

    task automatic add(input bit do_rst, input bit r, input bit l, input bit j,
                       input logic [32:0] v, input int ex, input int ey, input int eid);
        vec_t t;
        t.do_rst = do_rst; t.r = r; t.l = l; t.j = j; t.v = v;
        t.ex = ex; t.ey = ey; t.eid = eid;
        vecs.push_back(t);
    endtask

    task automatic do_reset(input logic [32:0] v);
        @(negedge clk);
        rst = 1'b0; view = v; right = 1'b0; left = 1'b0; jump = 1'b0; clk_10 = 1'b0;
        #1 check3("reset", 64, 400, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        prev_x = 64; prev_y = 400; prev_id = 0;
    endtask

    task automatic do_tick(input string name, input vec_t v);
        vec_t e;
        @(negedge clk);
        right = v.r; left = v.l; jump = v.j; view = v.v; clk_10 = 1'b1;
        exp_q.push_back(v);
        repeat (2) @(posedge clk);
        #1 check3({name, ".early"}, prev_x, prev_y, prev_id);
        @(posedge clk);
        #1 e = exp_q.pop_front();
        check3(name, e.ex, e.ey, e.eid);
        prev_x = e.ex; prev_y = e.ey; prev_id = e.eid;
        // Scramble inputs between ticks; nothing may move until the next strobe edge.
        right = 1'($urandom); left = 1'($urandom); jump = 1'($urandom); view = 33'($urandom);
        repeat (4) @(posedge clk);
        #1 check3({name, ".hold_high"}, prev_x, prev_y, prev_id);
        @(negedge clk);
        clk_10 = 1'b0;
        repeat (4) @(posedge clk);
        #1 check3({name, ".hold_low"}, prev_x, prev_y, prev_id);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t mj;
        // Idle after reset.
        add(1, 0, 0, 0, 33'd0,   64, 400, 0);
        add(0, 0, 0, 0, 33'd0,   64, 400, 0);
        add(0, 0, 0, 0, 33'd0,   64, 400, 0);
        // Walk right, frames cycle 1,2,3,1,2.
        add(0, 1, 0, 0, 33'd0,   68, 400, 1);
        add(0, 1, 0, 0, 33'd0,   72, 400, 2);
        add(0, 1, 0, 0, 33'd0,   76, 400, 3);
        add(0, 1, 0, 0, 33'd0,   80, 400, 1);
        add(0, 1, 0, 0, 33'd0,   84, 400, 2);
        // Turn left, then idle and both-pressed keep facing left.
        add(0, 0, 1, 0, 33'd0,   80, 400, 35);
        add(0, 0, 0, 0, 33'd0,   80, 400, 32);
        add(0, 1, 1, 0, 33'd0,   80, 400, 32);
        // Camera far right: lower clamp, then upper clamp on idle and walking ticks.
        add(1, 1, 0, 0, 33'd640, 0,   400, 1);
        add(0, 1, 0, 0, 33'd640, 4,   400, 2);
        add(0, 0, 0, 0, 33'd0,   624, 400, 0);
        add(0, 1, 0, 0, 33'd0,   624, 400, 1);
        // Pinned at the left edge of the view.
        add(1, 0, 1, 0, 33'd64,  0,   400, 33);
        add(0, 0, 1, 0, 33'd64,  0,   400, 34);
        add(0, 1, 0, 0, 33'd0,   68,  400, 3);
        // Full jump arc with relaunch.
        for (int k = 0; k < ARC_LEN; k++)
            add(k == 0, 0, 0, 1, 33'd0, 64, arc[k], 4);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].do_rst)
                do_reset(vecs[i].v);
            do_tick($sformatf("vec%0d", i), vecs[i]);
        end

        // Asynchronous reset in mid-jump with the strobe held high across release.
        do_reset(33'd0);
        for (int k = 0; k < 4; k++) begin
            mj.do_rst = 0; mj.r = 0; mj.l = 0; mj.j = 1; mj.v = 33'd0;
            mj.ex = 64; mj.ey = arc[k]; mj.eid = 4;
            do_tick($sformatf("mj%0d", k), mj);
        end
        @(negedge clk);
        right = 1'b0; left = 1'b0; jump = 1'b1; view = 33'd0; clk_10 = 1'b1;
        repeat (3) @(posedge clk);
        #1 check3("mj4", 64, 350, 4);
        @(negedge clk);
        rst = 1'b0;
        #1 check3("mj.async_reset", 64, 400, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(posedge clk);
        #1 check3("mj.no_tick_held_high", 64, 400, 0);
        @(negedge clk);
        clk_10 = 1'b0;
        repeat (4) @(posedge clk);
        prev_x = 64; prev_y = 400; prev_id = 0;
        mj.do_rst = 0; mj.r = 0; mj.l = 0; mj.j = 1; mj.v = 33'd0;
        mj.ex = 64; mj.ey = 388; mj.eid = 4;
        do_tick("mj.fresh_edge", mj);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/world.md
# world

Player-physics core of the platformer: tracks Mario's world position, walking, jumping and gravity, and emits his screen-space sprite position plus a sprite-frame ID. It sits between the debounced controller inputs and the renderer. It advances once per game tick, and the tick arrives as a slow strobe input sampled in the single system clock domain. The camera position `view` is owned upstream; this block only reads it.

## Interface
- GROUND_Y, 400: sprite top y when standing on the ground.
- WALK_STEP, 4: horizontal pixels moved per tick.
- JUMP_V, 12: initial upward speed, in px/tick.
- GRAVITY, 1: speed added per tick while airborne.
- X_SPAN, 624: maximum screen x (640 minus the 16-px sprite width).
- clk  in  1  system clock; all state is in this domain.
- rst  in  1  asynchronous, active-low reset.
- clk_10  in  1  10 Hz game-tick strobe. It is a data input, not a clock: it is synchronized with 2 FFs, and its rising edge produces a one-cycle `tick`.
- jump  in  1  jump button, level-sensitive.
- left  in  1  walk-left button.
- right  in  1  walk-right button.
- view  in  33  camera left edge, in world pixels.
- mario_x  out  11  sprite screen x, registered.
- mario_y  out  10  sprite screen y, registered.
- mario_id  out  6  sprite frame: bit 5 = facing left; bits 4:0 select the frame.

## Operation
- State held:
  - world_x, 33 bits.
  - y, 10 bits.
  - vy, signed 8 bits.
  - air flag.
  - facing.
  - walk frame counter, values 1..3.
- All state changes only on cycles where `tick`=1.
- Horizontal movement:
  - right=1, left=0: world_x+WALK_STEP, facing right.
  - left=1, right=0: world_x−WALK_STEP, facing left.
  - Both or neither: no horizontal move; facing is unchanged.
  - After the step, world_x is clamped to [view, view+X_SPAN]. This clamp runs every tick, including idle ticks.
- mario_x ← world_x_new − view, so it is always within 0..624.
- Vertical movement:
  - On ground (air=0) with jump=1: y ← y−JUMP_V, vy ← −(JUMP_V−GRAVITY), air ← 1.
  - Airborne: if y+vy ≥ GROUND_Y, then y ← GROUND_Y, vy ← 0, air ← 0. Otherwise y ← y+vy, vy ← vy+GRAVITY.
  - Holding jump relaunches on the first tick after landing. Horizontal control stays active in the air.
- mario_y ← y.
- mario_id selection:
  - Airborne: 4.
  - On ground and moving: current walk frame. The frame advances 1→2→3→1 on each moving ground tick.
  - On ground and idle: 0, and the frame counter resets to 1.
  - Bit 5 is set to the facing value.
- Reset values:
  - world_x=64, mario_x=64.
  - y=mario_y=400.
  - vy=0, air=0.
  - facing right, frame=1, mario_id=0.

## Timing
- The clk_10 rising edge reaches `tick` after the 2-FF synchronizer plus the edge register. Outputs update on the clk edge where `tick` is high, i.e. 3 clk cycles after the clk_10 rise.
- Exactly one update happens per clk_10 rising edge. Holding clk_10 high or low produces no further updates.
- Asserting rst at any time asynchronously restores all reset values, including clearing the synchronizer. The first tick after release then requires a fresh clk_10 rising edge.
- Buttons and view are sampled on the tick cycle only; changes between ticks are ignored.
- Full jump arc: 25 ticks from launch to landing. Peak y=322 is reached at tick 12, and y is held at 322 for tick 13.

## Test plan
- Reset, view=0, no buttons, run 3 ticks → mario_x=64, mario_y=400, mario_id=0 on every tick.
- view=0, right=1, 5 ticks → mario_x 68,72,76,80,84; mario_id 1,2,3,1,2.
- view=640, right=1 held from reset → tick 1 clamps world_x to 640 (mario_x=0); tick 2 gives mario_x=4.
- left=1 with world_x=view → mario_x stays 0 and mario_id=33 (facing left, frame 1).
- jump=1 held, view=0 → mario_y goes 388,377,…,322 (tick 12), 322 (tick 13), …, 400 (tick 25) with mario_id=4 throughout. Relaunch to 388 occurs at tick 26.
- Assert rst mid-jump (mario_y=350) → outputs immediately return to 64/400/0; with clk_10 held high after release, no update occurs until its next rising edge.
